hazard_stall_controller: RTL and testbench

//  Pipeline sequencing controller for the 5-stage core with a multi-cycle EX multiplier.
//  - Detects load-use hazards and inserts one bubble.
//  - Holds the front of the pipeline while a multiply occupies EX for MUL_LATENCY cycles.
//  - Flushes on taken branches.
//  - Counts stall cycles.

---
 rtl/hazard_stall_controller_pkg.sv | 21 ++
 rtl/hazard_load_use_detect.sv | 29 ++
 rtl/hazard_stall_controller.sv | 142 ++++++++++++++
 tb/tb_hazard_stall_controller.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_stall_controller_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hazard_pkg;

    // Two-bit encoding leaves spare codes so a corrupted state register is recoverable.
    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        MUL_BUSY = 2'b01
    } hz_state_e;

    // Default number of cycles a multiply occupies EX.
    localparam int MUL_LATENCY_DEF = 3;

    // Width of the multiply cycle counter; holds latencies up to 15.
    localparam int MUL_CNT_W = 4;

    // Instruction word loaded by the IF/ID and ID/EX bubble muxes (addi x0,x0,0).
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/hazard_load_use_detect.sv
// Flags a load in EX whose destination is a source of the instruction in ID.
// Latency: purely combinational, same cycle.
// Backpressure: none; the result only feeds the stall decision.
module hazard_load_use_detect #(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] i_id_rs1,
    input  logic [REG_ADDR_W-1:0] i_id_rs2,
    input  logic                  i_id_use_rs1,
    input  logic                  i_id_use_rs2,
    input  logic [REG_ADDR_W-1:0] i_ex_rd,
    input  logic                  i_ex_reg_write,
    input  logic                  i_ex_mem_read,
    output logic                  o_hazard
);

    logic w_rs1_match;
    logic w_rs2_match;
    logic w_load_wr;

    // x0 is never a real dependency, so a load targeting it cannot cause a hazard.
    always_comb begin
        w_load_wr   = i_ex_mem_read & i_ex_reg_write & (i_ex_rd != '0);
        w_rs1_match = i_id_use_rs1 & (i_id_rs1 == i_ex_rd);
        w_rs2_match = i_id_use_rs2 & (i_id_rs2 == i_ex_rd);
        o_hazard    = w_load_wr & (w_rs1_match | w_rs2_match);
    end

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline sequencing: multiply stall in EX, taken-branch flush, load-use bubble, stall perf counter.
// Latency: all controls combinational from inputs and FSM state; multiply result valid MUL_LATENCY-1 cycles after start.
// Backpressure: freezes PC/IF-ID/ID-EX while a multiply runs; holds PC/IF-ID one cycle on load-use.
module hazard_stall_controller
    import hazard_pkg::*;
#(
    parameter int MUL_LATENCY = MUL_LATENCY_DEF,
    parameter int REG_ADDR_W  = 5,
    parameter int CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_reg_write,
    input  logic                  ex_mem_read,
    input  logic                  ex_is_mul,
    input  logic                  ex_branch_tkn,
    output logic                  pc_hold,
    output logic                  if_id_hold,
    output logic                  id_ex_hold,
    output logic                  id_ex_bubble,
    output logic                  if_id_flush,
    output logic                  ex_mem_bubble,
    output logic                  mul_start,
    output logic                  mul_valid,
    output logic [CNT_W-1:0]      stall_cnt
);

    // Legal MUL_LATENCY is 2..15, so the 4-bit counter always reaches it.
    localparam logic [MUL_CNT_W-1:0] LP_LAT = MUL_CNT_W'(MUL_LATENCY);

    hz_state_e              r_state;
    hz_state_e              w_state_nxt;
    logic [MUL_CNT_W-1:0]   r_cnt;
    logic [MUL_CNT_W-1:0]   w_cnt_nxt;
    logic [CNT_W-1:0]       r_stall_cnt;

    logic w_load_use;
    logic w_fsm_idle;
    logic w_mul_stall;
    logic w_mul_start;
    logic w_mul_valid;
    logic w_branch;
    logic w_lu_stall;
    logic w_pc_hold;
    logic w_if_id_hold;
    logic w_id_ex_bubble;

    hazard_load_use_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_load_use (
        .i_id_rs1       (id_rs1),
        .i_id_rs2       (id_rs2),
        .i_id_use_rs1   (id_use_rs1),
        .i_id_use_rs2   (id_use_rs2),
        .i_ex_rd        (ex_rd),
        .i_ex_reg_write (ex_reg_write),
        .i_ex_mem_read  (ex_mem_read),
        .o_hazard       (w_load_use)
    );

    // Multiply FSM state and cycle counter; reset abandons any multiply in flight.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state and multiply controls; the counter starts at 2 so the result lands on cycle MUL_LATENCY.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_fsm_idle  = 1'b0;
        w_mul_stall = 1'b0;
        w_mul_start = 1'b0;
        w_mul_valid = 1'b0;
        case (r_state)
            IDLE: begin
                w_fsm_idle = 1'b1;
                if (ex_is_mul) begin
                    w_mul_start = 1'b1;
                    w_mul_stall = 1'b1;
                    w_state_nxt = MUL_BUSY;
                    w_cnt_nxt   = MUL_CNT_W'(2);
                end
            end
            MUL_BUSY: begin
                if (r_cnt < LP_LAT) begin
                    w_mul_stall = 1'b1;
                    w_cnt_nxt   = r_cnt + MUL_CNT_W'(1);
                end else begin
                    // Result cycle: ex_is_mul still shows the same multiply, so it is ignored here.
                    w_mul_valid = 1'b1;
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Pipeline controls with priority multiply stall > branch flush > load-use.
    always_comb begin
        w_branch       = w_fsm_idle & ~w_mul_stall & ex_branch_tkn;
        w_lu_stall     = ~w_mul_stall & ~w_branch & w_load_use;
        w_pc_hold      = w_mul_stall | w_lu_stall;
        w_if_id_hold   = w_mul_stall | w_lu_stall;
        w_id_ex_bubble = w_branch | w_lu_stall;
    end

    // Saturating count of cycles in which the PC is frozen.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_stall_cnt <= '0;
        end else if (w_pc_hold && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    // Every output is forced low while reset is held, including the combinational ones.
    assign pc_hold       = arst_n & w_pc_hold;
    assign if_id_hold    = arst_n & w_if_id_hold;
    assign id_ex_hold    = arst_n & w_mul_stall;
    assign id_ex_bubble  = arst_n & w_id_ex_bubble;
    assign if_id_flush   = arst_n & w_branch;
    assign ex_mem_bubble = arst_n & w_mul_stall;
    assign mul_start     = arst_n & w_mul_start;
    assign mul_valid     = arst_n & w_mul_valid;
    assign stall_cnt     = r_stall_cnt;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Scoreboard bench: driver computes expected controls from a cycle-level model, monitor compares at negedge.
// Latency: expected values are for the same cycle the stimulus is applied.
// Backpressure: n/a.
module tb_hazard_stall_controller;

    localparam int L  = 3;
    localparam int RW = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          arst_n;
    logic [RW-1:0] id_rs1, id_rs2, ex_rd;
    logic          id_use_rs1, id_use_rs2, ex_reg_write, ex_mem_read, ex_is_mul, ex_branch_tkn;

    logic        pc_hold, if_id_hold, id_ex_hold, id_ex_bubble, if_id_flush, ex_mem_bubble, mul_start, mul_valid;
    logic [31:0] stall_cnt;
    logic        d4_pc_hold, d4_if_id_hold, d4_id_ex_hold, d4_id_ex_bubble, d4_if_id_flush, d4_ex_mem_bubble;
    logic        d4_mul_start, d4_mul_valid;
    logic [3:0]  d4_stall_cnt;

    hazard_stall_controller #(.MUL_LATENCY(L), .REG_ADDR_W(RW), .CNT_W(32)) dut (
        .clk(clk), .arst_n(arst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_is_mul(ex_is_mul),
        .ex_branch_tkn(ex_branch_tkn), .pc_hold(pc_hold), .if_id_hold(if_id_hold),
        .id_ex_hold(id_ex_hold), .id_ex_bubble(id_ex_bubble), .if_id_flush(if_id_flush),
        .ex_mem_bubble(ex_mem_bubble), .mul_start(mul_start), .mul_valid(mul_valid),
        .stall_cnt(stall_cnt)
    );

    hazard_stall_controller #(.MUL_LATENCY(L), .REG_ADDR_W(RW), .CNT_W(4)) dut4 (
        .clk(clk), .arst_n(arst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_is_mul(ex_is_mul),
        .ex_branch_tkn(ex_branch_tkn), .pc_hold(d4_pc_hold), .if_id_hold(d4_if_id_hold),
        .id_ex_hold(d4_id_ex_hold), .id_ex_bubble(d4_id_ex_bubble), .if_id_flush(d4_if_id_flush),
        .ex_mem_bubble(d4_ex_mem_bubble), .mul_start(d4_mul_start), .mul_valid(d4_mul_valid),
        .stall_cnt(d4_stall_cnt)
    );

    typedef struct packed {
        logic rst, is_mul, mem_rd, reg_wr, br, u1, u2;
        logic [RW-1:0] rd, rs1, rs2;
    } stim_t;

    typedef struct packed {
        logic pc_hold, if_id_hold, id_ex_hold, id_ex_bubble, if_id_flush, ex_mem_bubble, mul_start, mul_valid;
        logic [31:0] stall_cnt;
        logic [3:0]  stall4;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   running  = 1'b0;

    // Reference model: a multiply started at cycle s stalls cycles s..s+L-2 and delivers its result at s+L-1.
    int   cyc         = 0;
    bit   mul_active  = 1'b0;
    int   valid_cycle = 0;
    int   stall_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    endtask

    task automatic drive(input stim_t s);
        exp_t e;
        bit   hold_mul;
        bit   was_idle;
        bit   lu;
        @(posedge clk);
        #1;
        arst_n        = ~s.rst;
        ex_is_mul     = s.is_mul;
        ex_mem_read   = s.mem_rd;
        ex_reg_write  = s.reg_wr;
        ex_branch_tkn = s.br;
        id_use_rs1    = s.u1;
        id_use_rs2    = s.u2;
        ex_rd         = s.rd;
        id_rs1        = s.rs1;
        id_rs2        = s.rs2;
        e = '0;
        if (s.rst) begin
            mul_active  = 1'b0;
            stall_total = 0;
            cyc         = 0;
        end else begin
            e.stall_cnt = 32'(stall_total);
            e.stall4    = (stall_total > 15) ? 4'd15 : 4'(stall_total);
            hold_mul = 1'b0;
            was_idle = !mul_active;
            if (mul_active && cyc == valid_cycle) begin
                e.mul_valid = 1'b1;
                mul_active  = 1'b0;
            end else if (mul_active) begin
                hold_mul = 1'b1;
            end else if (s.is_mul) begin
                e.mul_start = 1'b1;
                hold_mul    = 1'b1;
                mul_active  = 1'b1;
                valid_cycle = cyc + L - 1;
            end
            lu = s.mem_rd && s.reg_wr && (s.rd != 0) &&
                 ((s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd));
            if (hold_mul) begin
                e.pc_hold = 1; e.if_id_hold = 1; e.id_ex_hold = 1; e.ex_mem_bubble = 1;
            end else if (was_idle && s.br) begin
                e.if_id_flush = 1; e.id_ex_bubble = 1;
            end else if (lu) begin
                e.pc_hold = 1; e.if_id_hold = 1; e.id_ex_bubble = 1;
            end
            if (e.pc_hold) stall_total++;
            cyc++;
        end
        exp_q.push_back(e);
    endtask

    function automatic stim_t idle_stim();
        stim_t s;
        s = '0;
        return s;
    endfunction

    // Monitor: one expected entry per cycle, compared away from the rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (running) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL scoreboard_empty: got no expected entry at t=%0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("pc_hold",       32'(pc_hold),       32'(e.pc_hold));
                    check("if_id_hold",    32'(if_id_hold),    32'(e.if_id_hold));
                    check("id_ex_hold",    32'(id_ex_hold),    32'(e.id_ex_hold));
                    check("id_ex_bubble",  32'(id_ex_bubble),  32'(e.id_ex_bubble));
                    check("if_id_flush",   32'(if_id_flush),   32'(e.if_id_flush));
                    check("ex_mem_bubble", 32'(ex_mem_bubble), 32'(e.ex_mem_bubble));
                    check("mul_start",     32'(mul_start),     32'(e.mul_start));
                    check("mul_valid",     32'(mul_valid),     32'(e.mul_valid));
                    check("stall_cnt",     stall_cnt,          e.stall_cnt);
                    check("stall_cnt_w4",  32'(d4_stall_cnt),  32'(e.stall4));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        stim_t s;
        arst_n = 1'b0;
        {id_rs1, id_rs2, ex_rd} = '0;
        {id_use_rs1, id_use_rs2, ex_reg_write, ex_mem_read, ex_is_mul, ex_branch_tkn} = '0;
        running = 1'b1;

        s = idle_stim(); s.rst = 1;
        drive(s); drive(s);

        // Single multiply: start c0, holds c0..c1, result c2.
        s = idle_stim(); s.is_mul = 1;
        drive(s); drive(s); drive(s);
        drive(idle_stim());

        // Back-to-back multiplies: starts at c0 and c3, four stall cycles.
        s = idle_stim(); s.rst = 1; drive(s);
        s = idle_stim(); s.is_mul = 1;
        for (int i = 0; i < 6; i++) drive(s);
        drive(idle_stim());
        check("b2b_stall_cnt", stall_cnt, 32'd4);

        // Load-use through rs2, then the same load targeting x0.
        s = idle_stim(); s.mem_rd = 1; s.reg_wr = 1; s.rd = 5; s.rs2 = 5; s.u2 = 1;
        drive(s);
        drive(idle_stim());
        s.rd = 0; s.rs2 = 0;
        drive(s);
        // Branch beats a load-use match.
        s = idle_stim(); s.mem_rd = 1; s.reg_wr = 1; s.rd = 7; s.rs1 = 7; s.u1 = 1; s.br = 1;
        drive(s);
        drive(idle_stim());

        // Reset pulsed during cycle 1 of a multiply.
        s = idle_stim(); s.is_mul = 1;
        drive(s);
        s.rst = 1; drive(s);
        for (int i = 0; i < 4; i++) drive(idle_stim());

        // Twenty load-use stalls saturate the 4-bit counter at 15.
        s = idle_stim(); s.rst = 1; drive(s);
        s = idle_stim(); s.mem_rd = 1; s.reg_wr = 1; s.rd = 3; s.rs1 = 3; s.u1 = 1;
        for (int i = 0; i < 20; i++) drive(s);
        drive(idle_stim());
        check("sat_stall_cnt_w4", 32'(d4_stall_cnt), 32'd15);
        check("sat_stall_cnt_w32", stall_cnt, 32'd20);

        // Randomised traffic with small register space so hazards are frequent.
        for (int i = 0; i < 2000; i++) begin
            s = idle_stim();
            s.rst    = ($urandom_range(0, 99) == 0);
            s.is_mul = ($urandom_range(0, 5) == 0);
            s.mem_rd = ($urandom_range(0, 2) == 0);
            s.reg_wr = ($urandom_range(0, 3) != 0);
            s.br     = ($urandom_range(0, 7) == 0);
            s.u1     = 1'($urandom_range(0, 1));
            s.u2     = 1'($urandom_range(0, 1));
            s.rd     = RW'($urandom_range(0, 3));
            s.rs1    = RW'($urandom_range(0, 3));
            s.rs2    = RW'($urandom_range(0, 3));
            drive(s);
        end

        @(negedge clk);
        #1;
        running = 1'b0;
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
